// File: rtl/vga_linefetch.sv
// Scanline prefetch controller: fills a ping-pong line buffer from the framebuffer
// one source line ahead of display, then serves each stored pixel on two advance cycles.
module vga_linefetch #(
    parameter logic [16:0] BASE  = 17'd0,
    parameter int unsigned WIDTH = 320,
    parameter int unsigned LINES = 240
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        newline,
    input  logic        advance,
    input  logic [7:0]  line,
    output logic [11:0] pixel,
    output logic        rd_req,
    output logic [16:0] rd_addr,
    input  logic        rd_ack,
    input  logic [11:0] rd_data,
    output logic        busy,
    output logic        underrun
);

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    state_t      state, state_next;
    logic [7:0]  target;
    logic [7:0]  tgt_q;
    logic [8:0]  idx;
    logic [9:0]  xcnt;
    logic [1:0]  tag_valid;
    logic [7:0]  tag_line [2];
    logic [11:0] bank0 [WIDTH];
    logic [11:0] bank1 [WIDTH];
    logic        start;
    logic        last;
    logic        disp;
    logic        hit;
    logic [16:0] tgt_ext;
    logic [16:0] fetch_addr;

    // Last visible line and every vblank value prefetch line 0 for the next frame.
    assign target = (line < 8'(LINES - 1)) ? line + 8'd1 : '0;

    // T*320 as two shifts keeps the address path multiplier-free.
    assign tgt_ext    = {9'd0, tgt_q};
    assign fetch_addr = BASE + (tgt_ext << 8) + (tgt_ext << 6) + {8'd0, idx};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        last       = 1'b0;
        rd_req     = 1'b0;
        busy       = 1'b0;
        rd_addr    = '0;
        case (state)
            IDLE: begin
                if (newline && !(tag_valid[target[0]] && tag_line[target[0]] == target)) begin
                    start      = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                rd_req  = 1'b1;
                busy    = 1'b1;
                rd_addr = fetch_addr;
                if (rd_ack && idx == 9'(WIDTH - 1)) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_valid <= '0;
            tgt_q     <= '0;
            idx       <= '0;
        end else if (start) begin
            tag_valid[target[0]] <= 1'b0;
            tgt_q                <= target;
            idx                  <= '0;
        end else if (state == FETCH && rd_ack) begin
            idx <= idx + 9'd1;
            if (last) begin
                tag_valid[tgt_q[0]] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && last) begin
            tag_line[tgt_q[0]] <= tgt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && state == FETCH && rd_ack) begin
            if (tgt_q[0]) begin
                bank1[idx] <= rd_data;
            end else begin
                bank0[idx] <= rd_data;
            end
        end
    end

    assign disp = line[0];
    assign hit  = tag_valid[disp] && (tag_line[disp] == line);

    always_comb begin
        pixel = '0;
        if (advance && hit) begin
            pixel = disp ? bank1[xcnt[9:1]] : bank0[xcnt[9:1]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xcnt     <= '0;
            underrun <= 1'b0;
        end else begin
            if (newline) begin
                xcnt <= '0;
            end else if (advance && xcnt != 10'(2 * WIDTH - 1)) begin
                xcnt <= xcnt + 10'd1;
            end
            if (advance && !hit) begin
                underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_linefetch.sv
// Randomized scoreboard bench for vga_linefetch: a line-level reference model predicts
// fetch addresses, busy/underrun state and the displayed pixel for every cycle.
module tb_vga_linefetch;

    localparam logic [16:0] BASE  = 17'd0;
    localparam int          WIDTH = 320;
    localparam int          LINES = 240;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        newline;
    logic        advance;
    logic [7:0]  line;
    logic [11:0] pixel;
    logic        rd_req;
    logic [16:0] rd_addr;
    logic        rd_ack;
    logic [11:0] rd_data;
    logic        busy;
    logic        underrun;

    logic [11:0] fbmem [0:131071];

    vga_linefetch #(
        .BASE (BASE),
        .WIDTH(WIDTH),
        .LINES(LINES)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .newline (newline),
        .advance (advance),
        .line    (line),
        .pixel   (pixel),
        .rd_req  (rd_req),
        .rd_addr (rd_addr),
        .rd_ack  (rd_ack),
        .rd_data (rd_data),
        .busy    (busy),
        .underrun(underrun)
    );

    always #20 clk = ~clk;

    assign rd_data = fbmem[rd_addr];

    typedef struct {
        bit          chk;
        bit          req;
        bit          under;
        bit          adv;
        logic [11:0] pix;
        logic [16:0] addr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: which source line each buffer half holds, and fetch progress.
    bit       m_known = 0;
    bit       m_valid [2];
    int       m_line  [2];
    bit       m_fetch = 0;
    int       m_t     = 0;
    int       m_cnt   = 0;
    int       m_x     = 0;
    bit       m_under = 0;
    int       ack_pct = 100;
    int       stall_left = 0;

    function automatic int next_target(input int ln);
        return (ln < LINES - 1) ? ln + 1 : 0;
    endfunction

    function automatic logic [16:0] src_addr(input int ln, input int px);
        return 17'((int'(BASE) + ln * WIDTH + px) & 32'h1ffff);
    endfunction

    task automatic step(input bit nl, input bit adv, input logic [7:0] ln, input bit rstn);
        exp_t e;
        bit   ack;
        bit   hit;
        int   lni;
        int   nt;
        @(posedge clk);
        #1;
        lni = int'(ln);
        ack = 1'b0;
        if (rstn && m_fetch) begin
            if (stall_left > 0 && m_cnt == 17) begin
                stall_left--;
            end else begin
                ack = ($urandom_range(0, 99) < ack_pct);
            end
        end
        rst_n   = rstn;
        newline = nl;
        advance = adv;
        line    = ln;
        rd_ack  = ack;

        hit     = m_valid[lni % 2] && m_line[lni % 2] == lni;
        e.chk   = m_known;
        e.req   = m_fetch;
        e.under = m_under;
        e.adv   = adv;
        e.addr  = src_addr(m_t, m_cnt);
        e.pix   = (adv && hit) ? fbmem[src_addr(lni, m_x / 2)] : 12'h000;
        sb.push_back(e);

        if (!rstn) begin
            m_known  = 1;
            m_valid[0] = 0;
            m_valid[1] = 0;
            m_fetch  = 0;
            m_cnt    = 0;
            m_x      = 0;
            m_under  = 0;
        end else begin
            if (adv && !hit) m_under = 1;
            if (nl) m_x = 0;
            else if (adv && m_x < 2 * WIDTH - 1) m_x++;
            if (m_fetch) begin
                if (ack) begin
                    m_cnt++;
                    if (m_cnt == WIDTH) begin
                        m_valid[m_t % 2] = 1;
                        m_line[m_t % 2]  = m_t;
                        m_fetch = 0;
                    end
                end
            end else if (nl) begin
                nt = next_target(lni);
                if (!(m_valid[nt % 2] && m_line[nt % 2] == nt)) begin
                    m_valid[nt % 2] = 0;
                    m_t     = nt;
                    m_cnt   = 0;
                    m_fetch = 1;
                end
            end
        end
    endtask

    task automatic scanline(input int ln, input int n_adv);
        step(1'b1, 1'b0, 8'(ln), 1'b1);
        for (int k = 0; k < 15; k++) step(1'b0, 1'b0, 8'(ln), 1'b1);
        for (int k = 0; k < n_adv; k++) step(1'b0, ln < LINES, 8'(ln), 1'b1);
        for (int k = 0; k < 800 - 16 - n_adv; k++) step(1'b0, 1'b0, 8'(ln), 1'b1);
    endtask

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    exp_t me;
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            me = sb.pop_front();
            if (me.chk) begin
                check("rd_req", int'(rd_req), int'(me.req));
                check("busy", int'(busy), int'(me.req));
                check("underrun", int'(underrun), int'(me.under));
                if (me.req) check("rd_addr", int'(rd_addr), int'(me.addr));
                if (me.adv) check("pixel", int'(pixel), int'(me.pix));
            end
        end
    end

    initial begin
        bit reached;
        for (int i = 0; i < 131072; i++) fbmem[i] = 12'($urandom);
        m_valid[0] = 0;
        m_valid[1] = 0;
        m_line[0]  = 0;
        m_line[1]  = 0;
        rst_n   = 1'b0;
        newline = 1'b0;
        advance = 1'b0;
        line    = '0;
        rd_ack  = 1'b0;

        repeat (3) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);

        ack_pct = 100;
        scanline(245, 0);
        scanline(245, 0);
        stall_left = 5;
        scanline(0, 640);
        ack_pct = 60;
        for (int ln = 1; ln < 4; ln++) scanline(ln, 640);
        scanline(4, 645);
        ack_pct = 0;
        scanline(5, 640);
        ack_pct = 100;
        scanline(6, 640);
        scanline(7, 640);
        for (int k = 0; k < 4; k++) begin
            ack_pct = $urandom_range(50, 100);
            scanline($urandom_range(100, 239), 640);
        end

        ack_pct = 100;
        scanline(238, 640);
        step(1'b1, 1'b0, 8'd239, 1'b1);
        reached = 0;
        for (int k = 0; k < 400; k++) begin
            if (m_fetch && m_cnt == 100) begin
                reached = 1;
                break;
            end
            step(1'b0, 1'b0, 8'd239, 1'b1);
        end
        check("wrap_fetch_reached_i100", int'(reached), 1);
        step(1'b0, 1'b0, 8'd239, 1'b0);
        step(1'b0, 1'b0, 8'd239, 1'b1);
        scanline(0, 640);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
